// File: rtl/obi_apb_demux_ss_if.sv
// OBI request/response channel plus shared APB bus with per-target select/response lines.
// Latency: none, wiring only.
// Backpressure: OBI uses req/gnt and rvalid/rready; APB targets stall via pready.
interface obi_apb_demux_ss_if #(
    parameter int unsigned NUM_TARGETS = 4,
    parameter int unsigned OBI_AW      = 32,
    parameter int unsigned OBI_DW      = 32,
    parameter int unsigned OBI_IDW     = 1,
    parameter int unsigned APB_AW      = 32,
    parameter int unsigned APB_DW      = 32
);
    // OBI request channel
    logic                          obi_req;
    logic                          obi_gnt;
    logic [OBI_AW-1:0]             obi_addr;
    logic                          obi_we;
    logic [OBI_DW/8-1:0]           obi_be;
    logic [OBI_DW-1:0]             obi_wdata;
    logic [OBI_IDW-1:0]            obi_aid;
    // OBI response channel
    logic                          obi_rvalid;
    logic                          obi_rready;
    logic [OBI_DW-1:0]             obi_rdata;
    logic                          obi_err;
    logic [OBI_IDW-1:0]            obi_rid;
    // Shared APB request lines
    logic [APB_AW-1:0]             apb_paddr;
    logic                          apb_penable;
    logic                          apb_pwrite;
    logic [APB_DW-1:0]             apb_pwdata;
    logic [APB_DW/8-1:0]           apb_pstrb;
    // Per-target APB lines
    logic [NUM_TARGETS-1:0]        apb_psel;
    logic [NUM_TARGETS-1:0]        apb_pready;
    logic [NUM_TARGETS-1:0]        apb_pslverr;
    logic [NUM_TARGETS*APB_DW-1:0] apb_prdata;

    // Bridge side: accepts OBI requests, drives the APB bus
    modport slave (
        input  obi_req, obi_addr, obi_we, obi_be, obi_wdata, obi_aid, obi_rready,
        input  apb_pready, apb_pslverr, apb_prdata,
        output obi_gnt, obi_rvalid, obi_rdata, obi_err, obi_rid,
        output apb_paddr, apb_penable, apb_pwrite, apb_pwdata, apb_pstrb, apb_psel
    );

    // Environment side: issues OBI requests, plays the APB targets
    modport master (
        output obi_req, obi_addr, obi_we, obi_be, obi_wdata, obi_aid, obi_rready,
        output apb_pready, apb_pslverr, apb_prdata,
        input  obi_gnt, obi_rvalid, obi_rdata, obi_err, obi_rid,
        input  apb_paddr, apb_penable, apb_pwrite, apb_pwdata, apb_pstrb, apb_psel
    );
endinterface

// File: rtl/obi_apb_demux_ss.sv
// OBI-to-APB bridge that decodes one of NUM_TARGETS equal windows and runs a single APB transfer.
// Latency: grant cycle 0, SETUP 1, ACCESS 2+, rvalid from cycle 3 (cycle 1 for decode errors).
// Backpressure: one outstanding request; no grant until the response is taken with rready.
module obi_apb_demux_ss #(
    parameter int unsigned        NUM_TARGETS    = 4,
    parameter int unsigned        OBI_AW         = 32,
    parameter int unsigned        OBI_DW         = 32,
    parameter int unsigned        OBI_IDW        = 1,
    parameter int unsigned        APB_AW         = 32,
    parameter int unsigned        APB_DW         = 32,
    parameter logic [OBI_AW-1:0]  ADDR_BASE      = 32'h0103_0000,
    parameter int unsigned        SS_SIZE        = 'h100,
    parameter int unsigned        TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_TARGETS-1:0] ss_ctrl_icn,
    output logic [7:0]             err_count,
    obi_apb_demux_ss_if.slave      bus
);

    localparam int unsigned SS_SHIFT = $clog2(SS_SIZE);
    localparam int unsigned IW       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                 state;
    logic [OBI_AW-1:0]      addr_q;
    logic                   we_q;
    logic [OBI_DW/8-1:0]    be_q;
    logic [OBI_DW-1:0]      wdata_q;
    logic [OBI_IDW-1:0]     aid_q;
    logic [IW-1:0]          idx_q;
    logic [NUM_TARGETS-1:0] psel_q;
    logic                   penable_q;
    logic                   rvalid_q;
    logic [OBI_DW-1:0]      rdata_q;
    logic                   err_q;
    logic [31:0]            tmo_cnt;
    logic [7:0]             err_count_q;

    logic [OBI_AW:0]        offset;
    logic [OBI_AW-1:0]      slot;
    logic [IW-1:0]          dec_idx;
    logic                   dec_hit;
    logic                   dec_en;
    logic                   pready_sel;
    logic                   pslverr_sel;
    logic [APB_DW-1:0]      prdata_sel;
    logic [7:0]             err_count_nxt;

    // Window decode; the extra top bit of offset is the borrow, set when addr < ADDR_BASE
    always_comb begin
        offset  = {1'b0, bus.obi_addr} - {1'b0, ADDR_BASE};
        slot    = offset[OBI_AW-1:0] >> SS_SHIFT;
        dec_idx = slot[IW-1:0];
        dec_hit = !offset[OBI_AW] && (slot < OBI_AW'(NUM_TARGETS));
        dec_en  = dec_hit && ss_ctrl_icn[dec_idx];
    end

    // Response lines of the currently selected target and the saturating error increment
    always_comb begin
        pready_sel    = bus.apb_pready[idx_q];
        pslverr_sel   = bus.apb_pslverr[idx_q];
        prdata_sel    = bus.apb_prdata[idx_q*APB_DW +: APB_DW];
        err_count_nxt = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
    end

    // Transfer FSM with all bus-facing outputs registered
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            aid_q       <= '0;
            idx_q       <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            tmo_cnt     <= '0;
            err_count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.obi_req) begin
                        addr_q  <= bus.obi_addr;
                        we_q    <= bus.obi_we;
                        be_q    <= bus.obi_be;
                        wdata_q <= bus.obi_wdata;
                        aid_q   <= bus.obi_aid;
                        idx_q   <= dec_idx;
                        if (dec_en) begin
                            psel_q <= NUM_TARGETS'(1) << dec_idx;
                            state  <= SETUP;
                        end else begin
                            // Miss or disabled target: answer with an error, APB stays idle
                            rvalid_q    <= 1'b1;
                            rdata_q     <= '0;
                            err_q       <= 1'b1;
                            err_count_q <= err_count_nxt;
                            state       <= RESP;
                        end
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    tmo_cnt   <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (pready_sel) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= we_q ? '0 : prdata_sel;
                        err_q     <= pslverr_sel;
                        if (pslverr_sel) begin
                            err_count_q <= err_count_nxt;
                        end
                        state     <= RESP;
                    end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
                        // Target never answered: abandon the access with an error
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rvalid_q    <= 1'b1;
                        rdata_q     <= '0;
                        err_q       <= 1'b1;
                        err_count_q <= err_count_nxt;
                        state       <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                RESP: begin
                    if (bus.obi_rready) begin
                        rvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Grant is combinational in IDLE and held low while reset is asserted
    assign bus.obi_gnt     = reset_n && (state == IDLE) && bus.obi_req;
    assign bus.obi_rvalid  = rvalid_q;
    assign bus.obi_rdata   = rdata_q;
    assign bus.obi_err     = err_q;
    assign bus.obi_rid     = aid_q;
    assign bus.apb_paddr   = APB_AW'(addr_q);
    assign bus.apb_penable = penable_q;
    assign bus.apb_pwrite  = we_q;
    assign bus.apb_pwdata  = wdata_q;
    assign bus.apb_pstrb   = we_q ? be_q : '0;
    assign bus.apb_psel    = psel_q;
    assign err_count       = err_count_q;

endmodule

// File: tb/tb_obi_apb_demux_ss.sv
// Bench for obi_apb_demux_ss: OBI master, four APB target models and a response scoreboard.
// Latency: expected response latency checked per transaction.
// Backpressure: exercises rready stalls, APB wait states, timeout and reset mid-transfer.
module tb_obi_apb_demux_ss;

    localparam int NT = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NT-1:0] ss_ctrl_icn;
    logic [7:0]    err_count;

    obi_apb_demux_ss_if #(.NUM_TARGETS(NT)) bus ();

    obi_apb_demux_ss #(
        .NUM_TARGETS    (NT),
        .ADDR_BASE      (32'h0103_0000),
        .SS_SIZE        ('h100),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ss_ctrl_icn (ss_ctrl_icn),
        .err_count   (err_count),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Free-running cycle number, used for latency measurement
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // APB target models: configurable wait states, hang, slave error and read data
    logic [31:0]    tgt_rdata [NT];
    int             tgt_wait  [NT];
    logic [NT-1:0]  tgt_hang;
    logic [NT-1:0]  tgt_slverr;
    int             acc_cnt = 0;
    logic [NT-1:0]  pready_v;
    logic [NT-1:0]  pslverr_v;
    logic [NT*32-1:0] prdata_v;

    always @(posedge clk) acc_cnt <= bus.apb_penable ? acc_cnt + 1 : 0;

    always_comb begin
        pready_v  = '0;
        pslverr_v = '0;
        prdata_v  = '0;
        for (int t = 0; t < NT; t++) begin
            pready_v[t]         = bus.apb_psel[t] && bus.apb_penable && !tgt_hang[t] && (acc_cnt >= tgt_wait[t]);
            pslverr_v[t]        = bus.apb_psel[t] && tgt_slverr[t];
            prdata_v[t*32 +: 32] = tgt_rdata[t];
        end
    end

    assign bus.apb_pready  = pready_v;
    assign bus.apb_pslverr = pslverr_v;
    assign bus.apb_prdata  = prdata_v;

    // APB bus monitor: per-target select cycles, access cycles, last access-phase values
    int          psel_cyc [NT] = '{default: 0};
    int          pen_cyc = 0;
    logic [31:0] obs_paddr = '0;
    logic [31:0] obs_pwdata = '0;
    logic [3:0]  obs_pstrb = '0;
    logic        obs_pwrite = 1'b0;
    bit          psel_bad = 1'b0;

    always @(negedge clk) begin
        for (int t = 0; t < NT; t++) if (bus.apb_psel[t]) psel_cyc[t]++;
        if (bus.apb_penable) begin
            pen_cyc++;
            obs_paddr  = bus.apb_paddr;
            obs_pwdata = bus.apb_pwdata;
            obs_pstrb  = bus.apb_pstrb;
            obs_pwrite = bus.apb_pwrite;
        end
        if (!$onehot0(bus.apb_psel) || (bus.obi_rvalid && (|bus.apb_psel))) psel_bad = 1'b1;
    end

    // Scoreboard of expected OBI responses
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        rid;
    } exp_t;
    exp_t exp_q [$];

    int n_checks = 0;
    int n_errs   = 0;
    int gcyc     = 0;
    int snap_psel [NT];
    int snap_pen  = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [NT-1:0] psel_mask();
        logic [NT-1:0] m;
        m = '0;
        for (int t = 0; t < NT; t++) m[t] = (psel_cyc[t] != snap_psel[t]);
        return m;
    endfunction

    // Issue one OBI request; record grant cycle and optionally push the expected response
    task automatic send(input logic [31:0] addr, input logic we, input logic [3:0] be,
                        input logic [31:0] wdata, input logic aid,
                        input logic [31:0] exp_rdata, input logic exp_err, input bit push);
        int n;
        snap_psel = psel_cyc;
        snap_pen  = pen_cyc;
        bus.obi_addr  = addr;
        bus.obi_we    = we;
        bus.obi_be    = be;
        bus.obi_wdata = wdata;
        bus.obi_aid   = aid;
        bus.obi_req   = 1'b1;
        #1;
        n = 0;
        while (!bus.obi_gnt && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.obi_gnt) check_eq("gnt_timeout", 0, 1);
        gcyc = cyc;
        if (push) exp_q.push_back('{exp_rdata, exp_err, aid});
        @(posedge clk); #1;
        bus.obi_req = 1'b0;
    endtask

    // Wait for the response, optionally stall rready, then pop and compare at the handshake
    task automatic recv(input string tag, input int stall, input int exp_lat);
        int          n;
        logic [31:0] rd;
        logic        er;
        exp_t        e;
        n = 0;
        @(negedge clk);
        while (!bus.obi_rvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.obi_rvalid) begin
            check_eq({tag, "_rvalid_timeout"}, 0, 1);
            return;
        end
        check_eq({tag, "_latency"}, 64'(cyc - gcyc), 64'(exp_lat));
        check_eq({tag, "_psel_in_resp"}, 64'(bus.apb_psel), 0);
        rd = bus.obi_rdata;
        er = bus.obi_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.obi_req = 1'b1;
                #1;
                check_eq({tag, "_no_gnt_in_resp"}, 64'(bus.obi_gnt), 0);
                bus.obi_req = 1'b0;
            end
            check_eq({tag, "_stall_stable"}, {bus.obi_rvalid, bus.obi_err, bus.obi_rdata}, {1'b1, er, rd});
        end
        bus.obi_rready = 1'b1;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_rdata"}, bus.obi_rdata, e.rdata);
            check_eq({tag, "_err"}, 64'(bus.obi_err), 64'(e.err));
            check_eq({tag, "_rid"}, 64'(bus.obi_rid), 64'(e.rid));
        end
        @(posedge clk); #1;
        bus.obi_rready = 1'b0;
        check_eq({tag, "_rvalid_drop"}, 64'(bus.obi_rvalid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stale;
        reset_n        = 1'b0;
        ss_ctrl_icn    = '1;
        bus.obi_req    = 1'b1;
        bus.obi_addr   = '0;
        bus.obi_we     = 1'b0;
        bus.obi_be     = '0;
        bus.obi_wdata  = '0;
        bus.obi_aid    = '0;
        bus.obi_rready = 1'b0;
        tgt_hang       = '0;
        tgt_slverr     = '0;
        for (int t = 0; t < NT; t++) begin
            tgt_wait[t]  = 0;
            tgt_rdata[t] = 32'hA000_0000 + 32'(t);
        end
        tgt_rdata[1] = 32'hCAFE_F00D;

        // Reset state, with req held high to show grant is blocked
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_gnt", 64'(bus.obi_gnt), 0);
        check_eq("rst_rvalid", 64'(bus.obi_rvalid), 0);
        check_eq("rst_apb", {bus.apb_psel, bus.apb_penable, bus.apb_pwrite, bus.apb_pstrb}, 0);
        check_eq("rst_paddr", bus.apb_paddr, 0);
        check_eq("rst_rsp", {bus.obi_rdata, bus.obi_err, bus.obi_rid}, 0);
        check_eq("rst_err_count", err_count, 0);
        bus.obi_req = 1'b0;
        reset_n     = 1'b1;
        @(posedge clk); #1;

        // Read target 1, ready in the first access cycle
        send(32'h0103_0104, 1'b0, 4'hF, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 1);
        recv("rd_t1", 0, 3);
        check_eq("rd_t1_psel", psel_mask(), 4'b0010);
        check_eq("rd_t1_paddr", obs_paddr, 32'h0103_0104);
        check_eq("rd_t1_pstrb", obs_pstrb, 0);

        // Write target 3 with three wait states
        tgt_wait[3] = 3;
        send(32'h0103_0308, 1'b1, 4'b0011, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1);
        recv("wr_t3", 0, 6);
        tgt_wait[3] = 0;
        check_eq("wr_t3_psel", psel_mask(), 4'b1000);
        check_eq("wr_t3_apb", {obs_pwrite, obs_pstrb, obs_pwdata}, {1'b1, 4'b0011, 32'h1234_5678});
        check_eq("wr_t3_pen_cycles", 64'(pen_cyc - snap_pen), 4);

        // Decode miss above the last window
        send(32'h0104_0000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        recv("miss", 0, 1);
        check_eq("miss_psel", psel_mask(), 0);

        // Disabled target 2
        ss_ctrl_icn = 4'b1011;
        send(32'h0103_0200, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b1, 1);
        recv("dis_t2", 0, 1);
        ss_ctrl_icn = '1;
        check_eq("dis_t2_psel", psel_mask(), 0);
        check_eq("err_count_2", err_count, 2);

        // Timeout on target 0
        tgt_hang[0] = 1'b1;
        send(32'h0103_0010, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        recv("tmo_t0", 0, 6);
        tgt_hang[0] = 1'b0;
        check_eq("tmo_pen_cycles", 64'(pen_cyc - snap_pen), 4);
        check_eq("tmo_psel", psel_mask(), 4'b0001);
        check_eq("err_count_3", err_count, 3);

        // Slave error on a write to target 2
        tgt_slverr[2] = 1'b1;
        send(32'h0103_0280, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1, 1);
        recv("slverr_t2", 0, 3);
        tgt_slverr[2] = 1'b0;
        check_eq("err_count_4", err_count, 4);

        // Response held by rready low for five cycles
        send(32'h0103_0100, 1'b0, 4'hF, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 1);
        recv("stall_t1", 5, 3);

        // Reset in the middle of an ACCESS phase: no response may follow
        tgt_hang[0] = 1'b1;
        send(32'h0103_0020, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1'b0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("pre_rst_penable", 64'(bus.apb_penable), 1);
        reset_n     = 1'b0;
        bus.obi_req = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_rst_gnt", 64'(bus.obi_gnt), 0);
        check_eq("mid_rst_apb", {bus.apb_psel, bus.apb_penable, bus.apb_pwrite, bus.apb_pstrb}, 0);
        check_eq("mid_rst_rsp", {bus.obi_rvalid, bus.obi_rdata, bus.obi_err, bus.obi_rid}, 0);
        check_eq("mid_rst_paddr", bus.apb_paddr, 0);
        check_eq("mid_rst_err_count", err_count, 0);
        bus.obi_req = 1'b0;
        reset_n     = 1'b1;
        tgt_hang[0] = 1'b0;
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.obi_rvalid || (|bus.apb_psel)) stale = 1'b1;
        end
        check_eq("post_rst_stale", 64'(stale), 0);
        check_eq("post_rst_sb_empty", 64'(exp_q.size()), 0);

        // Fresh read after reset starts from IDLE with minimum latency
        @(posedge clk); #1;
        send(32'h0103_0004, 1'b0, 4'hF, 32'h0, 1'b0, 32'hA000_0000, 1'b0, 1);
        recv("post_rst_rd", 0, 3);
        check_eq("post_rst_err_count", err_count, 0);

        check_eq("psel_onehot_and_idle", 64'(psel_bad), 0);
        check_eq("sb_drained", 64'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
